// File: rtl/mips_mem_arbiter.sv
// Single-port arbiter for the unified 1024x32 instruction/data SRAM.
// Data accesses win by default. Fetch and loader alternate below them. A starvation guard lifts fetch above data.
module mips_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halted,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {SRC_NONE, SRC_IF, SRC_DM, SRC_LD} src_e;

  src_e          sel;
  src_e          owner_q;
  logic          pend_q;
  logic          rr_q;      // 0: fetch wins the next IF/LD tie, 1: loader wins
  logic          rr_d;
  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          if_elig;
  logic          is_read;

  assign if_elig = if_req && !halted;

  // Grants are gated by rst_n so nothing leaks out while reset is held.
  always_comb begin
    sel  = SRC_NONE;
    rr_d = rr_q;
    if (!rst_n) begin
      sel = SRC_NONE;
    end else if (if_elig && starve_q == SW'(STARVE_MAX)) begin
      sel = SRC_IF;
    end else if (dm_req) begin
      sel = SRC_DM;
    end else if (if_elig && ld_req) begin
      sel  = rr_q ? SRC_LD : SRC_IF;
      rr_d = ~rr_q;
    end else if (if_elig) begin
      sel = SRC_IF;
    end else if (ld_req) begin
      sel = SRC_LD;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    is_read   = 1'b0;
    case (sel)
      SRC_IF: begin
        mem_en   = 1'b1;
        mem_addr = if_addr;
        is_read  = 1'b1;
      end
      SRC_DM: begin
        mem_en    = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
        is_read   = !dm_we;
      end
      SRC_LD: begin
        mem_en    = 1'b1;
        mem_we    = ld_we;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
        is_read   = !ld_we;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!if_elig || sel == SRC_IF)
      starve_d = '0;
    else if (starve_q != SW'(STARVE_MAX))
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      rr_q     <= 1'b0;
      pend_q   <= 1'b0;
      owner_q  <= SRC_NONE;
    end else begin
      starve_q <= starve_d;
      rr_q     <= rr_d;
      pend_q   <= is_read;
      owner_q  <= is_read ? sel : SRC_NONE;
    end
  end

  assign if_gnt = (sel == SRC_IF);
  assign dm_gnt = (sel == SRC_DM);
  assign ld_gnt = (sel == SRC_LD);

  assign if_rvalid = pend_q && owner_q == SRC_IF;
  assign dm_rvalid = pend_q && owner_q == SRC_DM;
  assign ld_rvalid = pend_q && owner_q == SRC_LD;

  // Return data is steered straight from the SRAM; non-owners see zero.
  assign if_rdata = if_rvalid ? mem_rdata : '0;
  assign dm_rdata = dm_rvalid ? mem_rdata : '0;
  assign ld_rdata = ld_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a 1-cycle-latency SRAM model and a read-return scoreboard.
module tb_mips_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          halted = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_gnt, dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          ld_req = 1'b0, ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic          ld_gnt, ld_rvalid;
  logic [DW-1:0] ld_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] sram    [0:1023];
  logic [DW-1:0] ref_mem [0:1023];

  typedef struct {
    int            owner;
    logic [DW-1:0] data;
  } ret_t;
  ret_t rq[$];

  int checks = 0;
  int errors = 0;

  mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .halted(halted),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // g: expected grant this cycle (0 none, 1 IF, 2 DM, 3 LD)
  task automatic cycle(input int g);
    ret_t          e;
    logic [AW-1:0] a;
    logic          w;
    logic [DW-1:0] wd;
    @(negedge clk);
    a  = (g == 1) ? if_addr : (g == 2) ? dm_addr : (g == 3) ? ld_addr : '0;
    w  = (g == 2) ? dm_we : (g == 3) ? ld_we : 1'b0;
    wd = (g == 2) ? dm_wdata : (g == 3) ? ld_wdata : '0;
    chk("if_gnt", 32'(if_gnt), 32'(g == 1));
    chk("dm_gnt", 32'(dm_gnt), 32'(g == 2));
    chk("ld_gnt", 32'(ld_gnt), 32'(g == 3));
    chk("mem_en", 32'(mem_en), 32'(g != 0));
    chk("mem_we", 32'(mem_we), 32'(w));
    chk("mem_addr", 32'(mem_addr), 32'(a));
    chk("mem_wdata", mem_wdata, wd);
    e.owner = 0;
    e.data  = '0;
    if (rq.size() > 0) e = rq.pop_front();
    chk("if_rvalid", 32'(if_rvalid), 32'(e.owner == 1));
    chk("dm_rvalid", 32'(dm_rvalid), 32'(e.owner == 2));
    chk("ld_rvalid", 32'(ld_rvalid), 32'(e.owner == 3));
    chk("if_rdata", if_rdata, (e.owner == 1) ? e.data : '0);
    chk("dm_rdata", dm_rdata, (e.owner == 2) ? e.data : '0);
    chk("ld_rdata", ld_rdata, (e.owner == 3) ? e.data : '0);
    if (g != 0) begin
      if (w) ref_mem[a] = wd;
      else begin
        e.owner = g;
        e.data  = ref_mem[a];
        rq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rq.delete();
    cycle(0);
    cycle(0);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
    sram[5] = 32'h1234ABCD; ref_mem[5] = 32'h1234ABCD;
    sram[7] = 32'hCAFE0007; ref_mem[7] = 32'hCAFE0007;
    sram[9] = 32'h00009999; ref_mem[9] = 32'h00009999;

    // reset state, requests pending while reset is held
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 10'd5;
    cycle(0);
    rst_n = 1'b1;

    // single fetch
    cycle(1);
    if_req = 1'b0;
    cycle(0);

    // DM vs IF with starvation promotion on the fifth contended cycle
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd7;
    if_req = 1'b1; if_addr = 10'd5;
    cycle(2); cycle(2); cycle(2); cycle(2); cycle(1); cycle(2);
    dm_req = 1'b0; if_req = 1'b0;
    cycle(0);

    // IF/LD round robin starts with IF after reset
    do_reset();
    if_req = 1'b1; if_addr = 10'd5;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 10'd9;
    cycle(1); cycle(3); cycle(1); cycle(3);
    if_req = 1'b0; ld_req = 1'b0;
    cycle(0);

    // same-address store collision: DM first, LD last writer
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd3; dm_wdata = 32'hAA;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 10'd3; ld_wdata = 32'hBB;
    cycle(2);
    dm_req = 1'b0; dm_we = 1'b0;
    cycle(3);
    ld_we = 1'b0;
    cycle(3);
    ld_req = 1'b0;
    cycle(0);
    chk("addr3_model", ref_mem[3], 32'hBB);

    // halted: fetch blocked, DM and LD served, starvation counter idle
    halted = 1'b1; if_req = 1'b1; if_addr = 10'd5;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd7;
    for (int i = 0; i < 6; i++) cycle(2);
    dm_req = 1'b0;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 10'd9;
    for (int i = 0; i < 4; i++) cycle(3);
    ld_req = 1'b0;
    halted = 1'b0;
    dm_req = 1'b1;
    cycle(2); cycle(2); cycle(2); cycle(2); cycle(1);
    dm_req = 1'b0; if_req = 1'b0;
    cycle(0);

    // halted rising right after a fetch grant still returns that fetch
    if_req = 1'b1; if_addr = 10'd5;
    cycle(1);
    halted = 1'b1;
    cycle(0);
    halted = 1'b0; if_req = 1'b0;
    cycle(0);

    // reset pulse drops a pending read return
    if_req = 1'b1; if_addr = 10'd5;
    cycle(1);
    do_reset();
    cycle(1);
    if_req = 1'b0;
    cycle(0);
    cycle(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
